uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised second-generation UART receiver. Handles runtime-selectable frame format: data length, parity and 1/2 stop bits. Uses 3-sample majority voting per bit. Buffers received words, each with per-word error flags, in an internal FIFO with a valid/ready output handshake. Sits between the `RX_IN_S` serial pin and the consuming bus logic, clocked at Prescale × baud.

## Interface
- `DATA_WIDTH`, 8: maximum data bits per frame, legal 5..9.
- `PRESCALE_WIDTH`, 6: width of `Prescale`.
- `FIFO_DEPTH`, 4: number of word entries; power of two, ≥2.
- `RX_CLK` in 1: sole clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `Prescale` in PRESCALE_WIDTH: oversampling ratio (RX_CLK cycles per bit). Values <4 behave as 4. Change only while idle.
- `data_len` in 4: data bits per frame, 5..DATA_WIDTH. Values outside that range behave as DATA_WIDTH.
- `parity_enable` in 1: frame carries a parity bit.
- `parity_type` in 1: 0 = even, 1 = odd.
- `stop_bits` in 1: 0 = one stop bit, 1 = two stop bits.
- `RX_IN_S` in 1: serial input, already synchronised, idle high.
- `RX_OUT_READY` in 1: consumer accepts the head word.
- `RX_OUT_P` out DATA_WIDTH: head word data, LSB-aligned, unused upper bits 0.
- `RX_OUT_V` out 1: FIFO non-empty.
- `parity_error` out 1: head word parity flag.
- `framing_error` out 1: head word stop-bit flag.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy.
- `break_det` out 1: one-cycle break pulse. Tied 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE → START when `RX_IN_S` is sampled 0. The edge counter clears to 0 on that edge.
- Edge counter runs 0..Prescale-1 per bit. The bit counter increments on wrap.
- Bit sampling: the bit value is the majority of `RX_IN_S` taken at edge counts P/2-1, P/2 and P/2+1, where P = Prescale and P/2 is a floor. The decision is registered on the P/2+1 edge.
- START: majority 1 means a glitch. Return to IDLE with no FIFO write and no flags.
- DATA: `data_len` bits, LSB first, shifted into the assembly register.
- PARITY: entered only if `parity_enable`. Error if XOR(data bits, parity bit) ≠ `parity_type`.
- STOP: check 1 or 2 stop bits. Any stop sample of 0 sets the framing flag.
- Completion: on the decision edge of the last stop bit, push {framing, parity, data} and go to IDLE. Do not wait out the remaining half bit, so back-to-back frames resynchronise on the next start edge.
- Words with errors are still pushed.
- FIFO behaviour:
  - First-word-fall-through; the outputs always present the head entry.
  - Pop occurs when `RX_OUT_V && RX_OUT_READY`.
  - Push while full without a pop: the word is dropped, contents are unchanged, and `overrun` pulses.
  - Push and pop in the same cycle while full: both succeed and `fifo_count` is unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- `RX_OUT_P`, `parity_error` and `framing_error` read 0 when empty.

## Timing
- Reset (`RST` = 0, asynchronous):
  - FSM goes to IDLE; counters and pointers clear.
  - All outputs read 0 and `fifo_count` = 0.
  - An in-flight frame is discarded.
- Reset release: the first start detection can occur on the first RX_CLK edge with `RST` = 1.
- Frame latency: `RX_OUT_V` rises 1 cycle after the last stop-bit decision edge. That edge falls (S + N + p + s − 1)·P + P/2 + 1 cycles after the start-detect edge, where:
  - S = 1 (start bit)
  - N = `data_len`
  - p = `parity_enable`
  - s = stop-bit count
- Pop: the head advances on the same edge and the new head is visible the next cycle. `fifo_count` updates on the same edge.
- `overrun` and `break_det` are asserted for exactly 1 cycle.

## Configuration
- Macro: `UART_RX_BREAK_DET_EN`.
- Defined: a frame whose start, all data bits, parity (if enabled) and every stop bit are all 0 is a break. On the last stop-bit decision edge:
  - `break_det` pulses.
  - Nothing is pushed.
  - The FSM enters BREAK_WAIT and stays there until `RX_IN_S` is sampled 1, then goes to IDLE.
- Not defined: there is no BREAK_WAIT state and `break_det` is constant 0. An all-zero frame is pushed as data 0 with `framing_error` = 1.

## Test plan
- P=8, 8N1, byte 0xA5 sent, READY=1 → one word 0xA5 with parity and framing flags 0, RX_OUT_V high for exactly 1 cycle.
- P=16, data_len=7, even parity, 2 stop bits, 0x35 sent with a wrong parity bit → word 0x35 with `parity_error`=1 and `framing_error`=0.
- 8N1, second stop... single stop bit driven 0, byte 0x3C → word 0x3C with `framing_error`=1. The next frame, sent immediately after, is received correctly.
- `RX_IN_S` low for 3 cycles at P=8 → FSM returns to IDLE, `fifo_count` stays 0.
- FIFO_DEPTH=4, READY=0, 5 frames 0x01..0x05 → `fifo_count`=4, `overrun` pulses once, then 4 pops return 0x01..0x04. A repeat with a push and pop in the same cycle on a full FIFO shows no overrun.
- With `UART_RX_BREAK_DET_EN`: line low for 2 frame times then high → one `break_det` pulse, no push, then 0x5A is received normally. Without the macro → a 0x00 word with `framing_error`=1 is pushed.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime frame format, 3-sample majority voting and a
// FWFT word FIFO carrying per-word parity/framing flags.
// Ports: RX_CLK/RST clock and async active-low reset; Prescale, data_len,
// parity_enable, parity_type, stop_bits select the frame format; RX_IN_S is
// the serial line; RX_OUT_P/RX_OUT_V/RX_OUT_READY form the output handshake
// with parity_error/framing_error flags; overrun, fifo_count and break_det
// report status. Define UART_RX_BREAK_DET_EN to enable line-break detection.
module uart_rx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        RX_CLK,
  input  logic                        RST,
  input  logic [PRESCALE_WIDTH-1:0]   Prescale,
  input  logic [3:0]                  data_len,
  input  logic                        parity_enable,
  input  logic                        parity_type,
  input  logic                        stop_bits,
  input  logic                        RX_IN_S,
  input  logic                        RX_OUT_READY,
  output logic [DATA_WIDTH-1:0]       RX_OUT_P,
  output logic                        RX_OUT_V,
  output logic                        parity_error,
  output logic                        framing_error,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        break_det
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_WIDTH + 2;
  localparam logic [3:0] DW4 = 4'(DATA_WIDTH);
  localparam logic [PRESCALE_WIDTH-1:0] PMIN = PRESCALE_WIDTH'(4);

`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`endif

  state_t state;

  logic [PRESCALE_WIDTH-1:0] p_eff;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [PRESCALE_WIDTH-1:0] cnt_nxt;
  logic [3:0] len_eff;
  logic [3:0] last_stop;
  logic [3:0] bit_cnt;
  logic smp_a, smp_b, dec, wrap;
  logic s0, s1, maj;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] data_al;
  logic par_acc, perr, ferr;
  logic last_dec, is_brk, push_c;
  logic [WW-1:0] word_c;

  assign p_eff = (Prescale < PMIN) ? PMIN : Prescale;
  assign half = p_eff >> 1;

  // cnt_nxt is the edge count this clock edge represents
  assign cnt_nxt = (cnt == p_eff - 1'b1) ? '0 : cnt + 1'b1;
  assign wrap  = (cnt_nxt == '0);
  assign smp_a = (cnt_nxt == half - 1'b1);
  assign smp_b = (cnt_nxt == half);
  assign dec   = (cnt_nxt == half + 1'b1);
  assign maj = (s0 & s1) | (s0 & RX_IN_S) | (s1 & RX_IN_S);

  assign len_eff = (data_len >= 4'd5 && data_len <= DW4)
                 ? data_len : DW4;
  // bit_cnt: 0 = start, 1..N = data, then parity, then stop(s)
  assign last_stop = len_eff + {3'b000, parity_enable}
                   + (stop_bits ? 4'd2 : 4'd1);

  // data arrives LSB first into the top of shreg
  assign data_al = shreg >> (DW4 - len_eff);

  assign last_dec = (state == STOP) && dec
                  && (bit_cnt == last_stop);

`ifdef UART_RX_BREAK_DET_EN
  logic ones;
  logic brk;
  assign is_brk = ~(ones | maj);
  assign break_det = brk;
`else
  assign is_brk = 1'b0;
  assign break_det = 1'b0;
`endif

  assign push_c = last_dec && !is_brk;
  assign word_c = {ferr | ~maj, perr, data_al};

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      ones    <= 1'b0;
      brk     <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_BREAK_DET_EN
      brk <= 1'b0;
`endif
      if (state == IDLE) begin
        if (!RX_IN_S) begin
          state   <= START;
          cnt     <= '0;
          bit_cnt <= '0;
          shreg   <= '0;
          par_acc <= 1'b0;
          perr    <= 1'b0;
          ferr    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          ones    <= 1'b0;
`endif
        end
`ifdef UART_RX_BREAK_DET_EN
      end else if (state == BREAK_WAIT) begin
        if (RX_IN_S) state <= IDLE;
`endif
      end else begin
        cnt <= cnt_nxt;
        if (wrap) bit_cnt <= bit_cnt + 1'b1;
        if (smp_a) s0 <= RX_IN_S;
        if (smp_b) s1 <= RX_IN_S;
        if (dec) begin
`ifdef UART_RX_BREAK_DET_EN
          ones <= ones | maj;
`endif
          unique case (state)
            START: state <= maj ? IDLE : DATA;
            DATA: begin
              shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
              par_acc <= par_acc ^ maj;
              if (bit_cnt == len_eff)
                state <= parity_enable ? PARITY : STOP;
            end
            PARITY: begin
              perr  <= par_acc ^ maj ^ parity_type;
              state <= STOP;
            end
            STOP: begin
              ferr <= ferr | ~maj;
              if (bit_cnt == last_stop) begin
`ifdef UART_RX_BREAK_DET_EN
                brk   <= is_brk;
                state <= is_brk ? BREAK_WAIT : IDLE;
`else
                state <= IDLE;
`endif
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic full, empty, pop, wr_en;
  logic [WW-1:0] head;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = !empty && RX_OUT_READY;
  // a pop on the same edge frees the slot for a push into a full FIFO
  assign wr_en = push_c && (!full || pop);

  always_ff @(posedge RX_CLK) begin
    if (wr_en) mem[wp] <= word_c;
  end

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_c && full && !pop;
      if (wr_en) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rp];
  assign RX_OUT_V      = !empty;
  assign RX_OUT_P      = empty ? '0 : head[DATA_WIDTH-1:0];
  assign parity_error  = empty ? 1'b0 : head[DATA_WIDTH];
  assign framing_error = empty ? 1'b0 : head[DATA_WIDTH+1];
  assign fifo_count    = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame formats, error flags, glitch
// rejection, FIFO overrun/full push-pop, break handling and reset.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] presc = 6'd8;
  logic [3:0] dlen = 4'd8;
  logic       par_en = 1'b0;
  logic       par_type = 1'b0;
  logic       stop2 = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] out_p;
  logic       out_v, perr, ferr, ovr, brk;
  logic [2:0] fcnt;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  int wcnt = 0;
  logic [9:0] words [0:63];
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int vhigh = 0;
  int v_rise = 0;
  logic v_prev = 1'b0;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .PRESCALE_WIDTH(6),
    .FIFO_DEPTH(4)
  ) dut (
    .RX_CLK(clk),
    .RST(rst_n),
    .Prescale(presc),
    .data_len(dlen),
    .parity_enable(par_en),
    .parity_type(par_type),
    .stop_bits(stop2),
    .RX_IN_S(rx),
    .RX_OUT_READY(ready),
    .RX_OUT_P(out_p),
    .RX_OUT_V(out_v),
    .parity_error(perr),
    .framing_error(ferr),
    .overrun(ovr),
    .fifo_count(fcnt),
    .break_det(brk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_v && ready && wcnt < 64) begin
        words[wcnt] <= {ferr, perr, out_p};
        wcnt <= wcnt + 1;
      end
      if (ovr) ovr_cnt <= ovr_cnt + 1;
      if (brk) brk_cnt <= brk_cnt + 1;
      if (out_v) vhigh <= vhigh + 1;
      if (out_v && !v_prev) v_rise <= cyc;
      v_prev <= out_v;
    end else begin
      v_prev <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [8:0] d, input bit flip,
                            input bit sv, output int c0);
    logic pb;
    pb = par_type ^ flip;
    rx = 1'b0;
    c0 = cyc;
    steps(int'(presc));
    for (int i = 0; i < int'(dlen); i++) begin
      rx = d[i];
      pb = pb ^ d[i];
      steps(int'(presc));
    end
    if (par_en) begin
      rx = pb;
      steps(int'(presc));
    end
    rx = sv;
    steps(int'(presc));
    if (stop2) steps(int'(presc));
    rx = 1'b1;
  endtask

  task automatic fmt_8n1(input logic [5:0] p);
    presc = p;
    dlen = 4'd8;
    par_en = 1'b0;
    par_type = 1'b0;
    stop2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    steps(3);
    chk++;
    if ({out_v, out_p, perr, ferr, ovr, brk} !== 13'd0) begin
      err++;
      $display("FAIL reset_outputs got v=%b p=%h pe=%b fe=%b o=%b b=%b want all 0",
               out_v, out_p, perr, ferr, ovr, brk);
    end
    chk++;
    if (fcnt !== 3'd0) begin
      err++;
      $display("FAIL reset_count got %0d want 0", fcnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_midframe();
    int base;
    fmt_8n1(6'd8);
    base = wcnt;
    rx = 1'b0;
    steps(30);
    #3 rst_n = 1'b0;
    #1;
    chk++;
    if (fcnt !== 3'd0 || out_v !== 1'b0) begin
      err++;
      $display("FAIL midframe_reset got cnt=%0d v=%b want 0 0", fcnt, out_v);
    end
    rx = 1'b1;
    step();
    rst_n = 1'b1;
    steps(100);
    chk++;
    if (wcnt - base !== 0 || fcnt !== 3'd0) begin
      err++;
      $display("FAIL midframe_discard got words=%0d cnt=%0d want 0 0",
               wcnt - base, fcnt);
    end
  endtask

  task automatic test_8n1();
    int base, vh0, c0;
    fmt_8n1(6'd8);
    ready = 1'b1;
    base = wcnt;
    vh0 = vhigh;
    send_frame(9'h0A5, 1'b0, 1'b1, c0);
    steps(10);
    chk++;
    if (wcnt - base !== 1) begin
      err++;
      $display("FAIL 8n1_count got %0d want 1", wcnt - base);
    end
    chk++;
    if (words[base] !== 10'h0A5) begin
      err++;
      $display("FAIL 8n1_word got %h want 0a5", words[base]);
    end
    chk++;
    if (vhigh - vh0 !== 1) begin
      err++;
      $display("FAIL 8n1_vwidth got %0d want 1", vhigh - vh0);
    end
    chk++;
    if (v_rise - c0 !== 78) begin
      err++;
      $display("FAIL 8n1_latency got %0d want 78", v_rise - c0);
    end
  endtask

  task automatic test_parity();
    int base, c0;
    presc = 6'd16;
    dlen = 4'd7;
    par_en = 1'b1;
    par_type = 1'b0;
    stop2 = 1'b1;
    ready = 1'b1;
    base = wcnt;
    send_frame(9'h035, 1'b1, 1'b1, c0);
    steps(10);
    chk++;
    if (wcnt - base !== 1 || words[base] !== 10'h135) begin
      err++;
      $display("FAIL parity_word got n=%0d w=%h want 1 135",
               wcnt - base, words[base]);
    end
    chk++;
    if (v_rise - c0 !== 170) begin
      err++;
      $display("FAIL parity_latency got %0d want 170", v_rise - c0);
    end
    base = wcnt;
    send_frame(9'h035, 1'b0, 1'b1, c0);
    steps(10);
    chk++;
    if (wcnt - base !== 1 || words[base] !== 10'h035) begin
      err++;
      $display("FAIL parity_good got n=%0d w=%h want 1 035",
               wcnt - base, words[base]);
    end
  endtask

  task automatic test_framing();
    int base, c0;
    fmt_8n1(6'd8);
    ready = 1'b1;
    base = wcnt;
    send_frame(9'h03C, 1'b0, 1'b0, c0);
    send_frame(9'h081, 1'b0, 1'b1, c0);
    steps(10);
    chk++;
    if (wcnt - base !== 2) begin
      err++;
      $display("FAIL framing_count got %0d want 2", wcnt - base);
    end
    chk++;
    if (words[base] !== 10'h23C) begin
      err++;
      $display("FAIL framing_word got %h want 23c", words[base]);
    end
    chk++;
    if (words[base+1] !== 10'h081) begin
      err++;
      $display("FAIL framing_next got %h want 081", words[base+1]);
    end
  endtask

  task automatic test_glitch();
    int base, c0;
    fmt_8n1(6'd8);
    ready = 1'b1;
    base = wcnt;
    rx = 1'b0;
    steps(3);
    rx = 1'b1;
    steps(20);
    chk++;
    if (fcnt !== 3'd0 || wcnt - base !== 0) begin
      err++;
      $display("FAIL glitch_nopush got cnt=%0d words=%0d want 0 0",
               fcnt, wcnt - base);
    end
    send_frame(9'h05A, 1'b0, 1'b1, c0);
    steps(10);
    chk++;
    if (wcnt - base !== 1 || words[base] !== 10'h05A) begin
      err++;
      $display("FAIL glitch_after got n=%0d w=%h want 1 05a",
               wcnt - base, words[base]);
    end
  endtask

  task automatic test_overrun();
    int base, o0, c0;
    logic [9:0] exp_w;
    fmt_8n1(6'd8);
    ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(9'(i), 1'b0, 1'b1, c0);
    steps(10);
    chk++;
    if (fcnt !== 3'd4) begin
      err++;
      $display("FAIL overrun_count got %0d want 4", fcnt);
    end
    chk++;
    if (ovr_cnt - o0 !== 1) begin
      err++;
      $display("FAIL overrun_pulse got %0d want 1", ovr_cnt - o0);
    end
    chk++;
    if (out_v !== 1'b1 || out_p !== 8'h01) begin
      err++;
      $display("FAIL overrun_head got v=%b p=%h want 1 01", out_v, out_p);
    end
    base = wcnt;
    ready = 1'b1;
    steps(10);
    ready = 1'b0;
    chk++;
    if (wcnt - base !== 4 || fcnt !== 3'd0) begin
      err++;
      $display("FAIL overrun_drain got n=%0d cnt=%0d want 4 0",
               wcnt - base, fcnt);
    end
    for (int i = 0; i < 4; i++) begin
      exp_w = 10'(i + 1);
      chk++;
      if (words[base+i] !== exp_w) begin
        err++;
        $display("FAIL overrun_pop%0d got %h want %h", i, words[base+i], exp_w);
      end
    end
  endtask

  task automatic test_full_pushpop();
    int base, o0, c0, cs;
    logic [9:0] exp_w;
    fmt_8n1(6'd8);
    ready = 1'b0;
    base = wcnt;
    for (int i = 0; i < 4; i++) send_frame(9'(8'h11 + i), 1'b0, 1'b1, c0);
    steps(5);
    o0 = ovr_cnt;
    fork
      send_frame(9'h015, 1'b0, 1'b1, c0);
      begin
        cs = cyc;
        steps(77);
        if (cyc - cs != 77) $display("note: pop timing skew %0d", cyc - cs);
        ready = 1'b1;
        step();
        ready = 1'b0;
      end
    join
    steps(10);
    chk++;
    if (ovr_cnt - o0 !== 0) begin
      err++;
      $display("FAIL pushpop_overrun got %0d want 0", ovr_cnt - o0);
    end
    chk++;
    if (fcnt !== 3'd4) begin
      err++;
      $display("FAIL pushpop_count got %0d want 4", fcnt);
    end
    ready = 1'b1;
    steps(10);
    ready = 1'b0;
    chk++;
    if (wcnt - base !== 5) begin
      err++;
      $display("FAIL pushpop_words got %0d want 5", wcnt - base);
    end
    for (int i = 0; i < 5; i++) begin
      exp_w = 10'(8'h11 + i);
      chk++;
      if (words[base+i] !== exp_w) begin
        err++;
        $display("FAIL pushpop_pop%0d got %h want %h", i, words[base+i], exp_w);
      end
    end
  endtask

  task automatic test_break();
    int base, b0, c0;
    fmt_8n1(6'd8);
    ready = 1'b1;
    base = wcnt;
    b0 = brk_cnt;
`ifdef UART_RX_BREAK_DET_EN
    rx = 1'b0;
    steps(160);
    rx = 1'b1;
    steps(20);
    chk++;
    if (brk_cnt - b0 !== 1) begin
      err++;
      $display("FAIL break_pulse got %0d want 1", brk_cnt - b0);
    end
    chk++;
    if (wcnt - base !== 0 || fcnt !== 3'd0) begin
      err++;
      $display("FAIL break_nopush got n=%0d cnt=%0d want 0 0",
               wcnt - base, fcnt);
    end
    send_frame(9'h05A, 1'b0, 1'b1, c0);
    steps(10);
    chk++;
    if (wcnt - base !== 1 || words[base] !== 10'h05A) begin
      err++;
      $display("FAIL break_after got n=%0d w=%h want 1 05a",
               wcnt - base, words[base]);
    end
`else
    send_frame(9'h000, 1'b0, 1'b0, c0);
    steps(20);
    chk++;
    if (wcnt - base !== 1 || words[base] !== 10'h200) begin
      err++;
      $display("FAIL zero_frame got n=%0d w=%h want 1 200",
               wcnt - base, words[base]);
    end
    chk++;
    if (brk_cnt - b0 !== 0) begin
      err++;
      $display("FAIL zero_nobreak got %0d want 0", brk_cnt - b0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_8n1();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_full_pushpop();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
